// File: rtl/mem_ram_ctrl.sv
// Memory-bus slave: word RAM with programmable wait states, one MMIO console
// register feeding a byte FIFO, and a sticky error flag for unmapped accesses.
module mem_ram_ctrl #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready,
    output logic        bus_error
);

    localparam int              AW        = $clog2(DEPTH_WORDS);
    localparam int              PW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [31:0]     RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;
    typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_STAT} rsel_t;

    state_t        state_q, state_d;
    rsel_t         rsel_q, rsel_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [1:0]    status_q, status_d;
    logic          bus_error_q, bus_error_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   ram_mem [DEPTH_WORDS];
    logic [31:0]   ram_rdata_q;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          is_ram, is_console, is_write;
    logic          fifo_full, fifo_empty;
    logic          stall, go, push, pop, ram_we, ram_re;
    logic [AW-1:0] ram_idx;
    logic          unused_bits;

    assign is_ram      = addr_q < RAM_BYTES;
    assign is_console  = addr_q == CONSOLE_ADDR;
    assign is_write    = wstrb_q != 4'b0000;
    assign ram_idx     = addr_q[AW+1:2];
    assign fifo_full   = count_q == FIFO_FULL;
    assign fifo_empty  = count_q == '0;
    assign stall       = is_console && wstrb_q[0] && fifo_full;
    assign go          = (state_q == WAIT) && (wait_cnt_q == 4'd0) && !stall;
    assign push        = go && is_console && wstrb_q[0];
    assign pop         = !fifo_empty && console_ready;
    assign ram_we      = go && is_ram && is_write && !reset;
    assign ram_re      = go && is_ram && !is_write;
    assign unused_bits = ^{mem_instr, addr_q[31:AW+2], addr_q[1:0]};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wait_cnt_d  = wait_cnt_q;
        rsel_d      = rsel_q;
        status_d    = status_q;
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    wstrb_d    = mem_wstrb;
                    wait_cnt_d = WAIT_INIT;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (!stall) begin
                    state_d = RESP;
                    // Response source is registered so mem_rdata holds between accesses
                    if (is_ram && !is_write) begin
                        rsel_d = SEL_RAM;
                    end else if (is_console && !is_write) begin
                        rsel_d   = SEL_STAT;
                        status_d = {fifo_full, fifo_empty};
                    end else begin
                        rsel_d = SEL_ZERO;
                    end
                    if (!is_ram && !is_console) begin
                        bus_error_d = 1'b1;
                    end
                end
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wait_cnt_q  <= '0;
            rsel_q      <= SEL_ZERO;
            status_q    <= '0;
            bus_error_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wait_cnt_q  <= wait_cnt_d;
            rsel_q      <= rsel_d;
            status_q    <= status_d;
            bus_error_q <= bus_error_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Unreset storage with a registered read port so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    ram_mem[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= ram_mem[ram_idx];
        end
        if (push && !reset) begin
            fifo_mem[wr_ptr_q] <= wdata_q[7:0];
        end
    end

    always_comb begin
        mem_rdata = 32'h0;
        case (rsel_q)
            SEL_RAM:  mem_rdata = ram_rdata_q;
            SEL_STAT: mem_rdata = {30'b0, status_q};
            default:  mem_rdata = 32'h0;
        endcase
    end

    assign mem_ready     = state_q == RESP;
    assign bus_error     = bus_error_q;
    assign console_valid = !fifo_empty;
    assign console_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Self-checking bench for mem_ram_ctrl: randomized RAM traffic against a word
// model, console FIFO against a byte queue, latency and error-flag checks.
module tb_mem_ram_ctrl;

    localparam logic [31:0] CONSOLE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready;
    logic        bus_error;

    logic        valid_w0, valid_w5, ready_w0, ready_w5;
    logic [31:0] w0_unused_rdata, w5_unused_rdata;
    logic        w0_unused_cvalid, w5_unused_cvalid, w0_unused_berr, w5_unused_berr;
    logic [7:0]  w0_unused_cdata, w5_unused_cdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ram_model [int];
    logic [7:0]  fifo_model [$];

    always #5 clk = ~clk;

    mem_ram_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .CONSOLE_ADDR(CONSOLE), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .console_valid(console_valid),
        .console_data(console_data), .console_ready(console_ready), .bus_error(bus_error));

    mem_ram_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .CONSOLE_ADDR(CONSOLE), .FIFO_DEPTH(8)) dut_w0 (
        .clk(clk), .reset(reset), .mem_valid(valid_w0), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(ready_w0), .mem_rdata(w0_unused_rdata), .console_valid(w0_unused_cvalid),
        .console_data(w0_unused_cdata), .console_ready(1'b0), .bus_error(w0_unused_berr));

    mem_ram_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(5), .CONSOLE_ADDR(CONSOLE), .FIFO_DEPTH(8)) dut_w5 (
        .clk(clk), .reset(reset), .mem_valid(valid_w5), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(ready_w5), .mem_rdata(w5_unused_rdata), .console_valid(w5_unused_cvalid),
        .console_data(w5_unused_cdata), .console_ready(1'b0), .bus_error(w5_unused_berr));

    // Reference RAM: byte lanes merged with plain masking arithmetic
    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        logic [31:0] m;
        w = ram_model.exists(idx) ? ram_model[idx] : 32'h0;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        ram_model[idx] = (w & ~m) | (d & m);
    endfunction

    // Core-like access: valid held until ready, then one DONE cycle before returning
    task automatic do_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] rd, output int lat, output logic width_ok);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = 1'($urandom_range(0, 1));
        lat = -1;
        rd  = 32'h0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                lat = c;
                rd  = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        @(negedge clk);
        width_ok = (mem_ready === 1'b0);
    endtask

    task automatic test_reset();
        int ready_seen;
        reset = 1'b1; mem_valid = 1'b0; valid_w0 = 1'b0; valid_w5 = 1'b0;
        console_ready = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0; mem_instr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 0", mem_ready); end
        n_checks++; if (mem_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata got %h want 0", mem_rdata); end
        n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bus_error got %b want 0", bus_error); end
        n_checks++; if (console_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_console_valid got %b want 0", console_valid); end
        n_checks++; if (console_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_console_data got %h want 00", console_data); end
        ready_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_ready !== 1'b0) ready_seen++;
        end
        n_checks++; if (ready_seen != 0) begin n_fail++; $display("[TB] FAIL reset_idle_ready got %0d pulses want 0", ready_seen); end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd;
        int lat;
        logic wok;
        do_access(32'h40, 32'hDEADBEEF, 4'b1111, rd, lat, wok);
        model_write(16, 32'hDEADBEEF, 4'b1111);
        n_checks++; if (lat != 3 || !wok) begin n_fail++; $display("[TB] FAIL strobe_wr1_latency got %0d (width_ok %b) want 3", lat, wok); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL strobe_wr1_rdata got %h want 0", rd); end
        do_access(32'h40, 32'h000000AA, 4'b0001, rd, lat, wok);
        model_write(16, 32'h000000AA, 4'b0001);
        n_checks++; if (lat != 3 || !wok) begin n_fail++; $display("[TB] FAIL strobe_wr2_latency got %0d (width_ok %b) want 3", lat, wok); end
        do_access(32'h40, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (lat != 3 || !wok) begin n_fail++; $display("[TB] FAIL strobe_rd_latency got %0d (width_ok %b) want 3", lat, wok); end
        n_checks++; if (rd !== 32'hDEADBEAA) begin n_fail++; $display("[TB] FAIL strobe_rd_data got %h want deadbeaa", rd); end
    endtask

    task automatic test_wait_sweep();
        int first0, first5, cnt0, cnt5;
        first0 = -1; first5 = -1; cnt0 = 0; cnt5 = 0;
        @(negedge clk);
        mem_addr = 32'h0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
        valid_w0 = 1'b1; valid_w5 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            valid_w0 = 1'b0; valid_w5 = 1'b0;
            if (ready_w0 === 1'b1) begin cnt0++; if (first0 < 0) first0 = c; end
            if (ready_w5 === 1'b1) begin cnt5++; if (first5 < 0) first5 = c; end
        end
        n_checks++; if (first0 != 2) begin n_fail++; $display("[TB] FAIL sweep_w0_cycle got %0d want 2", first0); end
        n_checks++; if (cnt0 != 1) begin n_fail++; $display("[TB] FAIL sweep_w0_width got %0d want 1", cnt0); end
        n_checks++; if (first5 != 7) begin n_fail++; $display("[TB] FAIL sweep_w5_cycle got %0d want 7", first5); end
        n_checks++; if (cnt5 != 1) begin n_fail++; $display("[TB] FAIL sweep_w5_width got %0d want 1", cnt5); end
    endtask

    task automatic test_ram_random();
        logic [31:0] rd, d;
        logic [3:0] s;
        int lat, idx;
        logic wok;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_access(32'(i * 4), d, 4'b1111, rd, lat, wok);
            model_write(i, d, 4'b1111);
        end
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 15);
            d   = $urandom;
            s   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_access(32'(idx * 4 + $urandom_range(0, 3)), d, s, rd, lat, wok);
            n_checks++; if (lat != 3 || !wok) begin n_fail++; $display("[TB] FAIL rand_latency op %0d got %0d (width_ok %b) want 3", n, lat, wok); end
            if (s == 4'h0) begin
                n_checks++; if (rd !== ram_model[idx]) begin n_fail++; $display("[TB] FAIL rand_read word %0d got %h want %h", idx, rd, ram_model[idx]); end
            end else begin
                model_write(idx, d, s);
                n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL rand_write_rdata word %0d got %h want 0", idx, rd); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [31:0] rd1, rd2;
        first = -1; second = -1; rd1 = 32'h0; rd2 = 32'h0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h40; mem_wstrb = 4'h0; mem_wdata = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                if (first < 0) begin first = c; rd1 = mem_rdata; end
                else begin second = c; rd2 = mem_rdata; break; end
            end
        end
        mem_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (first != 3 || second != 8) begin n_fail++; $display("[TB] FAIL b2b_timing got %0d/%0d want 3/8", first, second); end
        n_checks++; if (rd1 !== ram_model[16] || rd2 !== ram_model[16]) begin n_fail++; $display("[TB] FAIL b2b_data got %h/%h want %h", rd1, rd2, ram_model[16]); end
    endtask

    task automatic fill_console();
        logic [31:0] rd;
        int lat;
        logic wok;
        for (int i = 0; i < 8; i++) begin
            do_access(CONSOLE, {24'h0, 8'(8'h41 + i)}, 4'b0001, rd, lat, wok);
            fifo_model.push_back(8'(8'h41 + i));
            n_checks++; if (lat != 3 || !wok) begin n_fail++; $display("[TB] FAIL push_latency byte %0d got %0d want 3", i, lat); end
        end
    endtask

    task automatic test_console_backpressure();
        logic [31:0] rd;
        logic [7:0] exp;
        int lat, ready_seen, drained;
        logic wok;
        console_ready = 1'b0;
        do_access(CONSOLE, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL status_empty got %h want 1", rd); end
        fill_console();
        do_access(CONSOLE, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (rd !== 32'h2) begin n_fail++; $display("[TB] FAIL status_full got %h want 2", rd); end
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = CONSOLE; mem_wdata = 32'h49; mem_wstrb = 4'b0001;
        fifo_model.push_back(8'h49);
        ready_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_ready !== 1'b0) ready_seen++;
        end
        n_checks++; if (ready_seen != 0) begin n_fail++; $display("[TB] FAIL stall_no_ready got %0d pulses want 0", ready_seen); end
        n_checks++; if (console_valid !== 1'b1 || console_data !== fifo_model[0]) begin n_fail++; $display("[TB] FAIL stall_head got %b/%h want 1/%h", console_valid, console_data, fifo_model[0]); end
        console_ready = 1'b1;
        @(negedge clk);
        console_ready = 1'b0;
        void'(fifo_model.pop_front());
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_pop_edge_ready got %b want 0", mem_ready); end
        n_checks++; if (console_data !== fifo_model[0]) begin n_fail++; $display("[TB] FAIL stall_after_pop_head got %h want %h", console_data, fifo_model[0]); end
        @(negedge clk);
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_ready got %b want 1", mem_ready); end
        mem_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release_width got %b want 0", mem_ready); end
        drained = 0;
        console_ready = 1'b1;
        for (int c = 0; c < 20 && fifo_model.size() > 0; c++) begin
            if (console_valid === 1'b1) begin
                exp = fifo_model.pop_front();
                drained++;
                n_checks++; if (console_data !== exp) begin n_fail++; $display("[TB] FAIL drain_byte %0d got %h want %h", drained, console_data, exp); end
            end
            @(negedge clk);
        end
        console_ready = 1'b0;
        n_checks++; if (drained != 8 || console_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_count got %0d (valid %b) want 8 (0)", drained, console_valid); end
        do_access(CONSOLE, 32'h77, 4'b0010, rd, lat, wok);
        n_checks++; if (lat != 3 || console_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL console_nopush got lat %0d valid %b want 3/0", lat, console_valid); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, d;
        int lat;
        logic wok;
        d = $urandom;
        do_access(32'hFFC, d, 4'b1111, rd, lat, wok);
        model_write(1023, d, 4'b1111);
        do_access(32'hFFC, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (rd !== ram_model[1023]) begin n_fail++; $display("[TB] FAIL last_word got %h want %h", rd, ram_model[1023]); end
        n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("[TB] FAIL err_before got %b want 0", bus_error); end
        do_access(32'h1000, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (lat != 3 || rd !== 32'h0) begin n_fail++; $display("[TB] FAIL err_boundary got lat %0d rdata %h want 3/0", lat, rd); end
        n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set got %b want 1", bus_error); end
        do_access(32'h1000, $urandom, 4'b1111, rd, lat, wok);
        do_access(CONSOLE + 32'h4, 32'h55, 4'b0001, rd, lat, wok);
        n_checks++; if (console_valid !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("[TB] FAIL err_console_alias got valid %b rdata %h want 0/0", console_valid, rd); end
        do_access(32'h2000_0000, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (lat != 3 || !wok || rd !== 32'h0) begin n_fail++; $display("[TB] FAIL err_far got lat %0d rdata %h want 3/0", lat, rd); end
        do_access(32'h0, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (rd !== ram_model[0]) begin n_fail++; $display("[TB] FAIL err_no_side_effect got %h want %h", rd, ram_model[0]); end
        n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky got %b want 1", bus_error); end
    endtask

    task automatic test_reset_stall();
        logic [31:0] rd;
        int lat, ready_seen;
        logic wok;
        console_ready = 1'b0;
        fill_console();
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = CONSOLE; mem_wdata = 32'h5A; mem_wstrb = 4'b0001;
        ready_seen = 0;
        repeat (5) begin @(negedge clk); if (mem_ready !== 1'b0) ready_seen++; end
        reset = 1'b1;
        mem_valid = 1'b0;
        repeat (2) begin @(negedge clk); if (mem_ready !== 1'b0) ready_seen++; end
        reset = 1'b0;
        fifo_model.delete();
        repeat (3) begin @(negedge clk); if (mem_ready !== 1'b0) ready_seen++; end
        n_checks++; if (ready_seen != 0) begin n_fail++; $display("[TB] FAIL rst_stall_ready got %0d pulses want 0", ready_seen); end
        n_checks++; if (console_valid !== 1'b0 || console_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_stall_fifo got %b/%h want 0/00", console_valid, console_data); end
        n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stall_error got %b want 0", bus_error); end
        do_access(32'h40, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (lat != 3 || rd !== ram_model[16]) begin n_fail++; $display("[TB] FAIL rst_stall_read got lat %0d data %h want 3/%h", lat, rd, ram_model[16]); end
        do_access(CONSOLE, 32'h0, 4'b0000, rd, lat, wok);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("[TB] FAIL rst_stall_status got %h want 1", rd); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_byte_strobe();
        test_wait_sweep();
        test_ram_random();
        test_back_to_back();
        test_console_backpressure();
        test_out_of_range();
        test_reset_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
